ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU result and store data.
REQ-002 Parameter REG_ADDR_W, default 5, width of the destination register index.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  execute stage presents a result this cycle.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_alu_result  input  DATA_W  ALU result.
REQ-008 in_zero_flag  input  1  ALU zero flag.
REQ-009 in_store_data  input  DATA_W  rs2 value for stores.
REQ-010 in_rd  input  REG_ADDR_W  destination register.
REQ-011 in_ctrl  input  4  {reg_write, mem_read, mem_write, is_branch}.
REQ-012 in_branch_ne  input  1  branch is BNE (0 = BEQ); meaningful only when is_branch=1.
REQ-013 flush  input  1  synchronous discard of all held and incoming entries.
REQ-014 out_valid  output  1  head entry is valid.
REQ-015 out_ready  input  1  memory stage consumes the head this cycle.
REQ-016 out_alu_result, out_store_data, out_rd, out_ctrl  output  DATA_W, DATA_W, REG_ADDR_W, 4  head entry fields.
REQ-017 out_branch_taken  output  1  resolved branch decision of the head entry.
REQ-018 stall_cycles  output  16  saturating count of upstream back-pressure cycles.

Function
REQ-019 Storage is a 2-entry FIFO (skid buffer) with registered occupancy count 0..2.
REQ-020 in_ready = (count != 2), driven from registered state only, with no combinational path from out_ready.
REQ-021 out_valid = (count != 0); out_* fields come from the head entry, and are 0 when count=0.
REQ-022 Push occurs when in_valid & in_ready & !flush; pop occurs when out_valid & out_ready & !flush.
REQ-023 Push and pop in the same cycle leave count unchanged; at count=1 the pushed entry becomes the head on the next cycle.
REQ-024 Latency: an entry pushed into an empty stage appears on out_* one cycle later, and there is no bypass path.
REQ-025 At count=2, in_ready=0, so no push occurs even if pop occurs; in_ready returns to 1 the cycle after the pop.
REQ-026 The branch decision is computed at push: taken = is_branch & (in_branch_ne ? !in_zero_flag : in_zero_flag); it is stored per entry.
REQ-027 Non-branch entries store taken=0.
REQ-028 flush=1 sets count to 0 next cycle, drops any same-cycle push or pop, and takes priority over all other events.
REQ-029 Entries are never reordered, duplicated or modified while held.
REQ-030 stall_cycles increments by 1 each cycle with in_valid & !in_ready, saturates at 16'hFFFF, and is unaffected by flush.

Reset
REQ-031 While rst_n=0 (asynchronous): count=0, all entries 0, out_valid=0, out_* fields=0, out_branch_taken=0, stall_cycles=0.
REQ-032 in_ready=1 from the first cycle after reset release.
REQ-033 Reset asserted mid-transfer discards all held entries, and no partial entry appears after release.

Structure
REQ-034 Shared package ex_mem_pkg holds DATA_W, REG_ADDR_W, the ctrl bit-index constants, and the packed entry typedef {alu_result, store_data, rd, ctrl, branch_taken}.
REQ-035 The block is a single module with no sub-module; the FIFO uses two entry registers plus read/write pointers.

Verification
REQ-036 Single push: push in_alu_result=32'h0000_0006, rd=5, ctrl=4'b1000, out_ready=1 -> next cycle out_valid=1, out_alu_result=6, out_rd=5, then out_valid=0.
REQ-037 Back-pressure: out_ready=0, push A=1, B=2, C=3 on consecutive cycles -> in_ready=0 after B, C is held off, stall_cycles=1 per blocked cycle; release out_ready -> A, B, C leave in order.
REQ-038 Branch resolution: BEQ with zero_flag=1 -> taken=1; BNE with zero_flag=1 -> taken=0; BNE with zero_flag=0 -> taken=1; non-branch with zero_flag=1 -> taken=0.
REQ-039 Flush: count=2 with flush=1 and simultaneous in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed entries never appear.
REQ-040 Saturation and reset: hold in_valid=1 with a full stage for 65540 cycles -> stall_cycles=16'hFFFF; then pulse rst_n=0 between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared widths, control-bit positions and the held-entry layout for the EX/MEM stage.
package ex_mem_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // Bit positions inside the 4-bit ctrl bundle {reg_write, mem_read, mem_write, is_branch}
    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_READ  = 2;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_IS_BRANCH = 0;

    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            ctrl;
        logic                  branch_taken;
    } entry_t;

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a 2-entry skid FIFO. Branch direction is
// resolved as an entry is captured; in_ready depends only on registered occupancy.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = ex_mem_pkg::DATA_W,
    parameter int REG_ADDR_W = ex_mem_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic                  in_zero_flag,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [3:0]            in_ctrl,
    input  logic                  in_branch_ne,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [3:0]            out_ctrl,
    output logic                  out_branch_taken,
    output logic [15:0]           stall_cycles
);

    // Saturating increment for the back-pressure counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    entry_t     entry0;
    entry_t     entry1;
    entry_t     new_entry;
    entry_t     head;
    logic       push;
    logic       pop;
    logic       taken;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Resolve the branch and pack the incoming fields into one entry
    always_comb begin
        taken = 1'b0;
        if (in_ctrl[CTRL_IS_BRANCH]) begin
            taken = in_branch_ne ? ~in_zero_flag : in_zero_flag;
        end
        new_entry              = '0;
        new_entry.alu_result   = in_alu_result;
        new_entry.store_data   = in_store_data;
        new_entry.rd           = in_rd;
        new_entry.ctrl         = in_ctrl;
        new_entry.branch_taken = taken;
    end

    // Select the head entry; outputs read as zero whenever the stage is empty
    always_comb begin
        head = rd_ptr ? entry1 : entry0;
        if (!out_valid) begin
            head = '0;
        end
    end

    assign out_alu_result   = head.alu_result;
    assign out_store_data   = head.store_data;
    assign out_rd           = head.rd;
    assign out_ctrl         = head.ctrl;
    assign out_branch_taken = head.branch_taken;

    // Occupancy and pointers; flush empties the stage and outranks push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage: written only on push, never touched while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
        end else if (push) begin
            if (wr_ptr) begin
                entry1 <= new_entry;
            end else begin
                entry0 <= new_entry;
            end
        end
    end

    // Count cycles where upstream offers data but the stage is full; flush does not clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'd0;
        end else if (in_valid && !in_ready) begin
            stall_cycles <= sat_inc16(stall_cycles);
        end
    end

endmodule
